// File: rtl/rf_loader.sv
// Byte-stream front end for the matrix register file: packs eight accepted
// bytes into one row and issues one register-file write per row.
module rf_loader #(
    parameter int ROWS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       rf_enable,
    output logic       write,
    output logic [2:0] idx,
    output logic [7:0] rf_data_0,
    output logic [7:0] rf_data_1,
    output logic [7:0] rf_data_2,
    output logic [7:0] rf_data_3,
    output logic [7:0] rf_data_4,
    output logic [7:0] rf_data_5,
    output logic [7:0] rf_data_6,
    output logic [7:0] rf_data_7,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    state_t     state;
    logic [2:0] row_cnt;
    logic [2:0] byte_cnt;
    logic [7:0] lanes [8];

    // Every output is registered alongside the state it belongs to, so
    // s_ready never depends combinationally on s_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            byte_cnt  <= '0;
            s_ready   <= 1'b0;
            rf_enable <= 1'b0;
            write     <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                lanes[k] <= '0;
            end
        end else begin
            rf_enable <= 1'b0;
            write     <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                row_cnt  <= '0;
                byte_cnt <= '0;
                idx      <= '0;
                s_ready  <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= FILL;
                            row_cnt  <= '0;
                            byte_cnt <= '0;
                            idx      <= '0;
                            s_ready  <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    FILL: begin
                        if (s_valid && s_ready) begin
                            lanes[byte_cnt] <= s_data;
                            byte_cnt        <= byte_cnt + 3'd1;
                            if (byte_cnt == 3'd7) begin
                                state     <= WRITE;
                                s_ready   <= 1'b0;
                                rf_enable <= 1'b1;
                                write     <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        // idx only advances when the next row starts filling
                        if (row_cnt == LAST_ROW) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= FILL;
                            row_cnt  <= row_cnt + 3'd1;
                            idx      <= row_cnt + 3'd1;
                            byte_cnt <= '0;
                            s_ready  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state   <= IDLE;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rf_data_0 = lanes[0];
    assign rf_data_1 = lanes[1];
    assign rf_data_2 = lanes[2];
    assign rf_data_3 = lanes[3];
    assign rf_data_4 = lanes[4];
    assign rf_data_5 = lanes[5];
    assign rf_data_6 = lanes[6];
    assign rf_data_7 = lanes[7];

endmodule

// File: tb/tb_rf_loader.sv
// Bench for rf_loader: streams bytes into an 8-row and a 1-row instance and
// compares every register-file write against rows built from the byte stream.
`timescale 1ns/1ps
module tb_rf_loader;

    typedef logic [66:0] wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, abort8, s_valid8;
    logic [7:0] s_data8;
    logic       s_ready8, rf_enable8, write8, busy8, done8;
    logic [2:0] idx8;
    logic [7:0] d8 [8];

    logic       start1, abort1, s_valid1;
    logic [7:0] s_data1;
    logic       s_ready1, rf_enable1, write1, busy1, done1;
    logic [2:0] idx1;
    logic [7:0] d1 [8];

    rf_loader #(.ROWS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8),
        .s_valid(s_valid8), .s_data(s_data8), .s_ready(s_ready8),
        .rf_enable(rf_enable8), .write(write8), .idx(idx8),
        .rf_data_0(d8[0]), .rf_data_1(d8[1]), .rf_data_2(d8[2]), .rf_data_3(d8[3]),
        .rf_data_4(d8[4]), .rf_data_5(d8[5]), .rf_data_6(d8[6]), .rf_data_7(d8[7]),
        .busy(busy8), .done(done8)
    );

    rf_loader #(.ROWS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .s_valid(s_valid1), .s_data(s_data1), .s_ready(s_ready1),
        .rf_enable(rf_enable1), .write(write1), .idx(idx1),
        .rf_data_0(d1[0]), .rf_data_1(d1[1]), .rf_data_2(d1[2]), .rf_data_3(d1[3]),
        .rf_data_4(d1[4]), .rf_data_5(d1[5]), .rf_data_6(d1[6]), .rf_data_7(d1[7]),
        .busy(busy1), .done(done1)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int fill_cyc = 0;
    int done_cnt8 = 0, done_cnt1 = 0, done_cyc8 = 0, done_cyc1 = 0;
    wr_t obs8 [$];
    wr_t obs1 [$];
    logic [7:0] stim [64];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe and done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (write8) obs8.push_back({idx8, d8[7], d8[6], d8[5], d8[4], d8[3], d8[2], d8[1], d8[0]});
        if (write1) obs1.push_back({idx1, d1[7], d1[6], d1[5], d1[4], d1[3], d1[2], d1[1], d1[0]});
        if (done8) begin done_cnt8 = done_cnt8 + 1; done_cyc8 = cyc; end
        if (done1) begin done_cnt1 = done_cnt1 + 1; done_cyc1 = cyc; end
    end

    function automatic logic [71:0] outs8();
        return {s_ready8, rf_enable8, write8, busy8, done8, idx8,
                d8[7], d8[6], d8[5], d8[4], d8[3], d8[2], d8[1], d8[0]};
    endfunction

    function automatic logic [71:0] outs1();
        return {s_ready1, rf_enable1, write1, busy1, done1, idx1,
                d1[7], d1[6], d1[5], d1[4], d1[3], d1[2], d1[1], d1[0]};
    endfunction

    // Row r is simply bytes 8r..8r+7 of the stream, first byte in lane 0
    function automatic wr_t expRow(input int r);
        wr_t w;
        w[66:64] = 3'(r);
        for (int k = 0; k < 8; k++) w[8*k +: 8] = stim[8*r + k];
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic startLoad(input bit to1);
        if (to1) start1 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start8 = 1'b0;
        fill_cyc = cyc;
        checkOutput("start_to_fill", to1 ? s_ready1 : s_ready8, 1);
    endtask

    // mode 0: gap-free, 1: idle cycle after every 3rd byte, 2: random valid
    task automatic applyStimulus(input bit to1, input int first, input int last, input int mode);
        int  pos;
        int  guard;
        bit  gap;
        bit  v;
        bit  acc;
        pos = first;
        guard = 0;
        gap = 0;
        while (pos < last && guard < 2000) begin
            v = (mode == 1) ? !gap : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (to1) begin s_valid1 = v; s_data1 = stim[pos]; end
            else     begin s_valid8 = v; s_data8 = stim[pos]; end
            @(negedge clk);
            acc = v && (to1 ? s_ready1 : s_ready8);
            @(posedge clk); #1;
            gap = 0;
            if (acc) begin
                pos++;
                if (mode == 1 && ((pos - first) % 3 == 0)) gap = 1;
            end
            guard++;
        end
        s_valid1 = 1'b0;
        s_valid8 = 1'b0;
        if (pos < last) checkOutput("stream_timeout", 72'(pos), 72'(last));
    endtask

    task automatic waitDone(input bit to1, input int limit);
        bit seen;
        seen = 0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            seen = to1 ? done1 : done8;
        end
        checkOutput("done_seen", seen, 1);
        @(negedge clk);
        checkOutput("idle_after_done", to1 ? {s_ready1, busy1, done1, write1} : {s_ready8, busy8, done8, write8}, 0);
    endtask

    task automatic checkLoad(input bit to1, input int n_writes, input int n_done);
        wr_t q [$];
        int  dc;
        if (to1) begin q = obs1; dc = done_cnt1; end
        else     begin q = obs8; dc = done_cnt8; end
        checkOutput("write_count", 72'(q.size()), 72'(n_writes));
        for (int r = 0; r < n_writes && r < q.size(); r++)
            checkOutput($sformatf("row%0d", r), q[r], expRow(r));
        checkOutput("done_count", 72'(dc), 72'(n_done));
        obs8.delete();
        obs1.delete();
        done_cnt8 = 0;
        done_cnt1 = 0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        start8 = 0; abort8 = 0; s_valid8 = 0; s_data8 = 0;
        start1 = 0; abort1 = 0; s_valid1 = 0; s_data1 = 0;
        idleCycles(3);
        rst = 1'b0;
        idleCycles(1);
        checkOutput("reset_outs8", outs8(), 0);
        checkOutput("reset_outs1", outs1(), 0);

        // Gap-free ramp 0x00..0x3F
        for (int i = 0; i < 64; i++) stim[i] = 8'(i);
        startLoad(0);
        applyStimulus(0, 0, 64, 0);
        waitDone(0, 50);
        checkOutput("done_latency", 72'(done_cyc8 - fill_cyc), 72'(72));
        checkLoad(0, 8, 1);

        // Same ramp with a one-cycle hole after every third byte
        startLoad(0);
        applyStimulus(0, 0, 64, 1);
        waitDone(0, 50);
        checkLoad(0, 8, 1);

        // Random bytes with random source stalls
        for (int i = 0; i < 64; i++) stim[i] = 8'($urandom);
        startLoad(0);
        applyStimulus(0, 0, 64, 2);
        waitDone(0, 50);
        checkLoad(0, 8, 1);

        // Single-row instance
        for (int i = 0; i < 8; i++) stim[i] = 8'hA0 + 8'(i);
        startLoad(1);
        applyStimulus(1, 0, 8, 0);
        waitDone(1, 20);
        checkOutput("rows1_done_latency", 72'(done_cyc1 - fill_cyc), 72'(9));
        checkLoad(1, 1, 1);

        // Abort after the fifth byte of row 2
        for (int i = 0; i < 64; i++) stim[i] = 8'($urandom);
        startLoad(0);
        applyStimulus(0, 0, 21, 0);
        abort8 = 1'b1;
        @(posedge clk); #1;
        abort8 = 1'b0;
        checkOutput("abort_idle", {busy8, s_ready8, write8, done8}, 0);
        idleCycles(20);
        checkLoad(0, 2, 0);
        startLoad(0);
        applyStimulus(0, 0, 64, 0);
        waitDone(0, 50);
        checkLoad(0, 8, 1);

        // A start pulse mid-load must change nothing
        startLoad(0);
        applyStimulus(0, 0, 30, 0);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        checkOutput("start_ignored_busy", {busy8, idx8}, {1'b1, 3'd3});
        applyStimulus(0, 30, 64, 0);
        waitDone(0, 50);
        checkLoad(0, 8, 1);

        // Reset while row 4 is being written
        startLoad(0);
        applyStimulus(0, 0, 40, 0);
        checkOutput("pre_reset_write", {write8, idx8}, {1'b1, 3'd4});
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_midload_outs", outs8(), 0);
        rst = 1'b0;
        idleCycles(20);
        checkOutput("reset_stays_idle", outs8(), 0);
        checkLoad(0, 5, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
